// File: rtl/store_monitor.sv
// Store trace monitor: captures processor stores into a first-word fall-through FIFO
// and latches a one-shot PASS/FAIL verdict from the first store to CHECK_ADDR.
//
// state  | meaning
// S_WAIT | no store to CHECK_ADDR seen since reset
// S_PASS | first CHECK_ADDR store carried CHECK_DATA (terminal)
// S_FAIL | first CHECK_ADDR store carried other data (terminal)
module store_monitor #(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] CHECK_ADDR = 32'h00000064,
  parameter logic [31:0] CHECK_DATA = 32'h00000007
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_addr,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              store_total,
  output logic                     pass,
  output logic                     fail
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_WAIT, S_PASS, S_FAIL} state_t;

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   total_q, total_d;
  state_t        state_q, state_d;
  logic          pass_q, fail_q;
  logic          push, pop, accept;

  always_comb begin
    pop      = (count_q != '0) && rd_ready;
    // A full FIFO still takes a store when the head leaves in the same cycle.
    accept   = (count_q < CW'(DEPTH)) || pop;
    push     = MemWrite && accept;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    overflow_d = overflow_q | (MemWrite & ~accept);

    total_d = total_q;
    if (MemWrite && (total_q != 16'hFFFF)) total_d = total_q + 16'd1;

    // Verdict ignores FIFO occupancy: dropped stores still decide it.
    state_d = state_q;
    if ((state_q == S_WAIT) && MemWrite && (DataAdr == CHECK_ADDR))
      state_d = (WriteData == CHECK_DATA) ? S_PASS : S_FAIL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      total_q    <= '0;
      state_q    <= S_WAIT;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      total_q    <= total_d;
      state_q    <= state_d;
      pass_q     <= (state_d == S_PASS);
      fail_q     <= (state_d == S_FAIL);
    end
  end

  // Storage is deliberately unreset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= {DataAdr, WriteData};
  end

  assign rd_valid           = (count_q != '0);
  assign {rd_addr, rd_data} = mem_q[rd_ptr_q];
  assign count              = count_q;
  assign overflow           = overflow_q;
  assign store_total        = total_q;
  assign pass               = pass_q;
  assign fail               = fail_q;

endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 SHALL have parameter DEPTH, 8, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CHECK_ADDR, 32'h00000064, store address that decides the pass/fail verdict.
REQ-003 SHALL have parameter CHECK_DATA, 32'h00000007, expected data at CHECK_ADDR.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port MemWrite  input  1  processor store strobe; one store per cycle while high.
REQ-007 SHALL have port DataAdr  input  32  processor store address.
REQ-008 SHALL have port WriteData  input  32  processor store data.
REQ-009 SHALL have port rd_ready  input  1  trace consumer accepts head entry.
REQ-010 SHALL have port rd_valid  output  1  head entry available.
REQ-011 SHALL have port rd_addr  output  32  head entry address.
REQ-012 SHALL have port rd_data  output  32  head entry data.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  entries held, 0..DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky: a store was dropped.
REQ-015 SHALL have port store_total  output  16  stores seen since reset, saturating at 16'hFFFF.
REQ-016 SHALL have port pass  output  1  verdict PASS.
REQ-017 SHALL have port fail  output  1  verdict FAIL.

Function
REQ-018 SHALL push {DataAdr, WriteData} at a rising edge where MemWrite=1 and push is accepted.
REQ-019 SHALL accept a push when count<DEPTH, or when count=DEPTH and a pop occurs in the same cycle.
REQ-020 SHALL pop at a rising edge where rd_valid=1 and rd_ready=1; rd_ready with rd_valid=0 is ignored.
REQ-021 SHALL drive rd_valid = (count!=0) and present head entry on rd_addr/rd_data combinationally (first-word fall-through, zero-cycle read latency).
REQ-022 SHALL make a pushed entry visible on rd_valid the cycle after the push edge (one-cycle capture latency).
REQ-023 SHALL update count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL preserve FIFO contents and set overflow on a rejected push; overflow stays set until reset.
REQ-026 SHALL increment store_total on every MemWrite=1 edge, accepted or dropped, holding at 16'hFFFF.
REQ-027 SHALL implement verdict FSM with states WAIT, PASS, FAIL.
REQ-028 SHALL transition WAIT->PASS on MemWrite=1, DataAdr=CHECK_ADDR, WriteData=CHECK_DATA.
REQ-029 SHALL transition WAIT->FAIL on MemWrite=1, DataAdr=CHECK_ADDR, WriteData!=CHECK_DATA.
REQ-030 SHALL keep PASS and FAIL terminal until reset; later CHECK_ADDR stores do not alter the verdict.
REQ-031 SHALL evaluate the verdict independent of FIFO full/overflow state.
REQ-032 SHALL drive pass=(state==PASS), fail=(state==FAIL), registered, never both high.

Reset
REQ-033 SHALL, on reset assertion, immediately clear pointers, count, overflow, store_total, and set state WAIT, without waiting for clk.
REQ-034 SHALL hold rd_valid=0, pass=0, fail=0 while reset is high; FIFO storage contents are not reset.
REQ-035 SHALL discard a push or pop coincident with a reset edge; first capture occurs on the first rising edge after reset deasserts.

Verification
REQ-036 Reset then single store MemWrite=1, DataAdr=32'h64, WriteData=32'h7 -> next cycle rd_valid=1, rd_addr=32'h64, rd_data=32'h7, count=1, pass=1, fail=0, store_total=1.
REQ-037 Store 32'h64/32'h5 then 32'h64/32'h7 -> fail=1 after first edge, remains fail=1, pass=0 after second.
REQ-038 rd_ready=0, nine consecutive stores with DEPTH=8 -> count=8, overflow=1, store_total=9, head = first store; then drain eight pops in order, rd_valid=0, count=0.
REQ-039 Full FIFO, MemWrite=1 with rd_ready=1 same cycle -> count stays 8, overflow stays 0, newest entry at tail, oldest removed.
REQ-040 Twelve push/pop pairs interleaved -> pointers wrap, entries read back in exact store order.
REQ-041 Reset asserted mid-stream between clock edges with count=3, pass=1 -> count=0, rd_valid=0, pass=0 immediately; next CHECK_ADDR store re-decides verdict.
